// File: rtl/syscall_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : syscall_pkg
//  Description : Service codes, register indices and FSM encoding for the
//                syscall responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package syscall_pkg;

    localparam int DATA_W    = 32;
    localparam int RF_ADDR_W = 5;

    localparam logic [DATA_W-1:0] CODE_HALT  = 32'd10;
    localparam logic [DATA_W-1:0] CODE_DISP  = 32'd34;
    localparam logic [DATA_W-1:0] CODE_PAUSE = 32'd50;

    localparam logic [RF_ADDR_W-1:0] REG_V0 = 5'd2;
    localparam logic [RF_ADDR_W-1:0] REG_A0 = 5'd4;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        STATE_IDLE  = 3'd0,
        STATE_RD_A0 = 3'd1,
        STATE_EXEC  = 3'd2,
        STATE_PAUSE = 3'd3,
        STATE_HALT  = 3'd4,
        STATE_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/syscall_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : syscall_unit_if
//  Description : Decoder, register-file read port and board-indicator
//                signals of the syscall responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface syscall_unit_if #(
    parameter int CNT_W = 32
);
    import syscall_pkg::*;

    logic                 syscall_en;
    logic [RF_ADDR_W-1:0] rf_req;
    logic [DATA_W-1:0]    rf_data;
    logic                 resume;
    logic                 stall;
    logic                 halt;
    logic [DATA_W-1:0]    disp_data;
    logic                 disp_valid;
    logic [CNT_W-1:0]     cnt_syscall;

    modport slave (
        input  syscall_en, rf_data, resume,
        output rf_req, stall, halt, disp_data, disp_valid, cnt_syscall
    );

    modport master (
        output syscall_en, rf_data, resume,
        input  rf_req, stall, halt, disp_data, disp_valid, cnt_syscall
    );

endinterface
`default_nettype wire

// File: rtl/syscall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : syscall_unit
//  Description : Stalls the core on a syscall, fetches $v0/$a0 and executes
//                the display, halt or pause service, retiring it once.
//  Revision    : 1.0 - initial release
// ============================================================================
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    syscall_unit_if.slave  bus
);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_W-1:0]     r_code;
    logic [DATA_W-1:0]     r_arg;
    logic [DATA_W-1:0]     r_disp_data;
    logic                  r_disp_valid;
    logic                  r_halt;
    logic [CNT_W-1:0]      r_cnt;

    logic [RF_ADDR_W-1:0]  w_rf_req;
    logic                  w_stall;
    logic                  w_load_code;
    logic                  w_load_arg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= STATE_IDLE;
            r_code       <= '0;
            r_arg        <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_halt       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_next_state;
            r_disp_valid <= 1'b0;
            if (w_load_code) begin
                r_code <= bus.rf_data;
            end
            if (w_load_arg) begin
                r_arg <= bus.rf_data;
            end
            if (r_state == STATE_EXEC) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_code == CODE_DISP) begin
                    r_disp_data  <= r_arg;
                    r_disp_valid <= 1'b1;
                end
                if (r_code == CODE_HALT) begin
                    r_halt <= 1'b1;
                end
            end
        end
    end

    // DONE drops stall so the PC steps past the syscall; syscall_en is not
    // looked at there, which prevents the same instruction retriggering.
    always_comb begin
        w_next_state = r_state;
        w_rf_req     = '0;
        w_stall      = 1'b0;
        w_load_code  = 1'b0;
        w_load_arg   = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                if (bus.syscall_en) begin
                    w_rf_req     = REG_V0;
                    w_stall      = 1'b1;
                    w_load_code  = 1'b1;
                    w_next_state = STATE_RD_A0;
                end
            end
            STATE_RD_A0: begin
                w_rf_req     = REG_A0;
                w_stall      = 1'b1;
                w_load_arg   = 1'b1;
                w_next_state = STATE_EXEC;
            end
            STATE_EXEC: begin
                w_stall = 1'b1;
                if (r_code == CODE_HALT) begin
                    w_next_state = STATE_HALT;
                end else if (r_code == CODE_PAUSE) begin
                    w_next_state = STATE_PAUSE;
                end else begin
                    w_next_state = STATE_DONE;
                end
            end
            STATE_PAUSE: begin
                w_stall = 1'b1;
                if (bus.resume) begin
                    w_next_state = STATE_DONE;
                end
            end
            STATE_HALT: begin
                w_stall = 1'b1;
            end
            STATE_DONE: begin
                w_next_state = STATE_IDLE;
            end
            default: begin
                w_next_state = STATE_IDLE;
            end
        endcase
    end

    assign bus.rf_req      = w_rf_req;
    assign bus.stall       = w_stall;
    assign bus.halt        = r_halt;
    assign bus.disp_data   = r_disp_data;
    assign bus.disp_valid  = r_disp_valid;
    assign bus.cnt_syscall = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_syscall_unit
//  Description : Directed self-checking bench for syscall_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_syscall_unit;

    localparam int CNT_W = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = '0;
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    syscall_unit_if #(.CNT_W(CNT_W)) bus ();

    syscall_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Asynchronous register-file read port
    assign bus.rf_data = regs[bus.rf_req];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs a syscall through the detect, RD_A0 and EXEC edges.
    task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
        regs[2] = v0;
        regs[4] = a0;
        bus.syscall_en = 1'b1;
        tick;
        bus.syscall_en = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.syscall_en = 1'b0;
        bus.resume = 1'b0;
        tick;
        tick;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", bus.stall); end
        n_checks++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %0b want 0", bus.halt); end
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %0b want 0", bus.disp_valid); end
        n_checks++; if (bus.disp_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.disp_data); end
        n_checks++; if (bus.cnt_syscall !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", bus.cnt_syscall); end
        n_checks++; if (bus.rf_req !== 5'd0) begin n_fail++; $display("FAIL rst_rfreq: got %0d want 0", bus.rf_req); end
        rst_n = 1'b1;
        tick;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_idle_stall: got %0b want 0", bus.stall); end
    endtask

    task automatic test_display;
        regs[2] = 32'd34;
        regs[4] = 32'hDEADBEEF;
        bus.syscall_en = 1'b1;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL disp_stall_det: got %0b want 1", bus.stall); end
        n_checks++; if (bus.rf_req !== 5'd2) begin n_fail++; $display("FAIL disp_rfreq_v0: got %0d want 2", bus.rf_req); end
        tick;
        bus.syscall_en = 1'b0;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL disp_stall_rd: got %0b want 1", bus.stall); end
        n_checks++; if (bus.rf_req !== 5'd4) begin n_fail++; $display("FAIL disp_rfreq_a0: got %0d want 4", bus.rf_req); end
        tick;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL disp_stall_exec: got %0b want 1", bus.stall); end
        n_checks++; if (bus.rf_req !== 5'd0) begin n_fail++; $display("FAIL disp_rfreq_exec: got %0d want 0", bus.rf_req); end
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL disp_dv_exec: got %0b want 0", bus.disp_valid); end
        tick;
        exp_cnt = exp_cnt + 1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL disp_stall_done: got %0b want 0", bus.stall); end
        n_checks++; if (bus.disp_valid !== 1'b1) begin n_fail++; $display("FAIL disp_dv_done: got %0b want 1", bus.disp_valid); end
        n_checks++; if (bus.disp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL disp_data: got %h want deadbeef", bus.disp_data); end
        n_checks++; if (bus.cnt_syscall !== exp_cnt) begin n_fail++; $display("FAIL disp_cnt: got %0d want %0d", bus.cnt_syscall, exp_cnt); end
        tick;
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL disp_dv_after: got %0b want 0", bus.disp_valid); end
        n_checks++; if (bus.disp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL disp_data_hold: got %h want deadbeef", bus.disp_data); end
    endtask

    task automatic test_unknown;
        logic [31:0] codes [2];
        codes[0] = 32'd7;
        codes[1] = 32'h0000_0122;
        for (int k = 0; k < 2; k++) begin
            int n_stall;
            logic seen_dv;
            n_stall = 0;
            seen_dv = 1'b0;
            regs[2] = codes[k];
            regs[4] = 32'h1234_5678;
            bus.syscall_en = 1'b1;
            #1;
            for (int i = 0; i < 10; i++) begin
                if (bus.disp_valid) seen_dv = 1'b1;
                if (!bus.stall) break;
                n_stall++;
                tick;
                bus.syscall_en = 1'b0;
            end
            exp_cnt = exp_cnt + 1;
            if (bus.disp_valid) seen_dv = 1'b1;
            n_checks++; if (n_stall != 3) begin n_fail++; $display("FAIL unk_stall_len code=%0d: got %0d want 3", codes[k], n_stall); end
            n_checks++; if (seen_dv !== 1'b0) begin n_fail++; $display("FAIL unk_dv code=%0d: got %0b want 0", codes[k], seen_dv); end
            n_checks++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL unk_halt code=%0d: got %0b want 0", codes[k], bus.halt); end
            n_checks++; if (bus.cnt_syscall !== exp_cnt) begin n_fail++; $display("FAIL unk_cnt code=%0d: got %0d want %0d", codes[k], bus.cnt_syscall, exp_cnt); end
            n_checks++; if (bus.disp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL unk_data code=%0d: got %h want deadbeef", codes[k], bus.disp_data); end
            tick;
        end
    endtask

    task automatic test_pause;
        int n_low;
        bus.resume = 1'b1;
        tick;
        bus.resume = 1'b0;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL pause_idle_resume: got %0b want 0", bus.stall); end
        regs[2] = 32'd50;
        regs[4] = 32'h0;
        bus.syscall_en = 1'b1;
        tick;
        bus.syscall_en = 1'b0;
        bus.resume = 1'b1;
        tick;
        bus.resume = 1'b0;
        tick;
        exp_cnt = exp_cnt + 1;
        n_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.stall !== 1'b1) n_low++;
            tick;
        end
        n_checks++; if (n_low != 0) begin n_fail++; $display("FAIL pause_hold: got %0d unstalled cycles want 0", n_low); end
        bus.resume = 1'b1;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL pause_resume_cycle: got %0b want 1", bus.stall); end
        tick;
        bus.resume = 1'b0;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL pause_done_stall: got %0b want 0", bus.stall); end
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL pause_dv: got %0b want 0", bus.disp_valid); end
        n_checks++; if (bus.cnt_syscall !== exp_cnt) begin n_fail++; $display("FAIL pause_cnt: got %0d want %0d", bus.cnt_syscall, exp_cnt); end
        tick;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL pause_idle_after: got %0b want 0", bus.stall); end
    endtask

    task automatic test_back_to_back;
        issue(32'd34, 32'd1);
        exp_cnt = exp_cnt + 1;
        n_checks++; if (bus.disp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_dv1: got %0b want 1", bus.disp_valid); end
        n_checks++; if (bus.disp_data !== 32'd1) begin n_fail++; $display("FAIL b2b_data1: got %h want 1", bus.disp_data); end
        bus.syscall_en = 1'b1;
        regs[4] = 32'd2;
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ignores_en: got %0b want 0", bus.stall); end
        tick;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_stall: got %0b want 1", bus.stall); end
        n_checks++; if (bus.rf_req !== 5'd2) begin n_fail++; $display("FAIL b2b_restart_rfreq: got %0d want 2", bus.rf_req); end
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dv_gap: got %0b want 0", bus.disp_valid); end
        tick;
        bus.syscall_en = 1'b0;
        tick;
        tick;
        exp_cnt = exp_cnt + 1;
        n_checks++; if (bus.disp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_dv2: got %0b want 1", bus.disp_valid); end
        n_checks++; if (bus.disp_data !== 32'd2) begin n_fail++; $display("FAIL b2b_data2: got %h want 2", bus.disp_data); end
        n_checks++; if (bus.cnt_syscall !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", bus.cnt_syscall, exp_cnt); end
        tick;
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dv_end: got %0b want 0", bus.disp_valid); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_end: got %0b want 0", bus.stall); end
    endtask

    task automatic test_reset_mid_pause;
        issue(32'd50, 32'h0);
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rmp_paused: got %0b want 1", bus.stall); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        exp_cnt = '0;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rmp_stall: got %0b want 0", bus.stall); end
        n_checks++; if (bus.disp_data !== 32'h0) begin n_fail++; $display("FAIL rmp_data: got %h want 0", bus.disp_data); end
        n_checks++; if (bus.cnt_syscall !== 32'h0) begin n_fail++; $display("FAIL rmp_cnt: got %0d want 0", bus.cnt_syscall); end
        n_checks++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL rmp_halt: got %0b want 0", bus.halt); end
        n_checks++; if (bus.rf_req !== 5'd0) begin n_fail++; $display("FAIL rmp_rfreq: got %0d want 0", bus.rf_req); end
        bus.resume = 1'b1;
        tick;
        bus.resume = 1'b0;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rmp_idle: got %0b want 0", bus.stall); end
    endtask

    task automatic test_halt;
        int n_bad;
        issue(32'd10, 32'h55);
        exp_cnt = exp_cnt + 1;
        n_checks++; if (bus.cnt_syscall !== exp_cnt) begin n_fail++; $display("FAIL halt_cnt: got %0d want %0d", bus.cnt_syscall, exp_cnt); end
        n_bad = 0;
        for (int i = 0; i < 100; i++) begin
            bus.syscall_en = i[0];
            bus.resume = (i % 7 == 3);
            #1;
            if (bus.halt !== 1'b1 || bus.stall !== 1'b1 || bus.rf_req !== 5'd0) n_bad++;
            tick;
        end
        bus.syscall_en = 1'b0;
        bus.resume = 1'b0;
        n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles want 0", n_bad); end
        n_checks++; if (bus.cnt_syscall !== exp_cnt) begin n_fail++; $display("FAIL halt_cnt_frozen: got %0d want %0d", bus.cnt_syscall, exp_cnt); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        exp_cnt = '0;
        n_checks++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL halt_rst_halt: got %0b want 0", bus.halt); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL halt_rst_stall: got %0b want 0", bus.stall); end
        n_checks++; if (bus.cnt_syscall !== 32'h0) begin n_fail++; $display("FAIL halt_rst_cnt: got %0d want 0", bus.cnt_syscall); end
        issue(32'd34, 32'hCAFE_F00D);
        exp_cnt = exp_cnt + 1;
        n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL halt_recover: got dv=%0b data=%h want dv=1 data=cafef00d", bus.disp_valid, bus.disp_data); end
        n_checks++; if (bus.cnt_syscall !== exp_cnt) begin n_fail++; $display("FAIL halt_recover_cnt: got %0d want %0d", bus.cnt_syscall, exp_cnt); end
        tick;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        bus.syscall_en = 1'b0;
        bus.resume = 1'b0;
        test_reset;
        test_display;
        test_unknown;
        test_pause;
        test_back_to_back;
        test_reset_mid_pause;
        test_halt;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
Responder to the control decoder's syscall request. When the decoder flags the current instruction as a syscall, this block:
- stalls the core;
- reads $v0 (service code) and $a0 (argument) over a dedicated register-file read port;
- executes the service (display, halt, pause);
- releases the core so the syscall retires exactly once.

It sits beside the register file and PC, driving the PC stall and board display/halt indicators.

Parameters:
CODE_HALT, 10, $v0 value that halts the core permanently until reset
CODE_DISP, 34, $v0 value that latches $a0 onto the display
CODE_PAUSE, 50, $v0 value that stalls until resume pulse
REG_V0, 2, register index of service code
REG_A0, 4, register index of argument
CNT_W, 32, width of syscall counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
syscall_en  in  1  current instruction is syscall (from control decoder)
rf_req  out  5  register-file read address (dedicated read port, asynchronous read)
rf_data  in  32  read data for rf_req, valid same cycle
resume  in  1  single-cycle pulse from debounced button
stall  out  1  hold PC/instruction; combinational
halt  out  1  sticky halt indicator
disp_data  out  32  last displayed value
disp_valid  out  1  one-cycle pulse when disp_data updated
cnt_syscall  out  CNT_W  number of executed syscalls

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - code, arg, disp_data, cnt_syscall=0.
  - disp_valid=0, halt=0.
  - Reset overrides every state, including HALT and PAUSE.
- States: IDLE, RD_A0, EXEC, PAUSE, HALT, DONE (encoding in package).
- IDLE:
  - syscall_en=0: rf_req=0, stall=0, stay.
  - syscall_en=1: rf_req=REG_V0, stall=1, code<=rf_data, go RD_A0.
- RD_A0: rf_req=REG_A0, stall=1, arg<=rf_data, go EXEC.
- EXEC: stall=1, cnt_syscall<=cnt_syscall+1 (wraps modulo 2^CNT_W), then decode code:
  - CODE_DISP: disp_data<=arg, disp_valid<=1 for exactly the next cycle, go DONE.
  - CODE_HALT: halt<=1, go HALT.
  - CODE_PAUSE: go PAUSE.
  - other: no side effect, go DONE.
- PAUSE: stall=1; resume=1 -> DONE; else stay. resume outside PAUSE is ignored.
- HALT: stall=1, halt=1 forever; exit only via reset.
- DONE: stall=0 so the PC advances past the syscall at this edge; syscall_en is ignored in this state; go IDLE.
- rf_req=0 in EXEC, PAUSE, HALT, DONE.
- Latency:
  - non-halting service: stall high for exactly 3 cycles (IDLE-detect, RD_A0, EXEC) plus PAUSE cycles; DONE cycle unstalled.
  - disp_valid rises the cycle after EXEC (the DONE cycle).
- Back-to-back syscalls: a second syscall seen in IDLE the cycle after DONE starts a fresh sequence; no lost or duplicated execution.
- code compares full 32 bits; values above 6 bits are simply unknown codes.
- disp_data holds its value until the next CODE_DISP or reset.

Decomposition:
- Shared package (syscall_pkg): CODE_HALT/CODE_DISP/CODE_PAUSE, REG_V0/REG_A0, state encoding STATE_* with its width.
- Core-wide constants stay in the existing core header.
- No sub-module needed; single FSM plus datapath registers.

Test Plan:
- Display: $v0=34, $a0=0xDEADBEEF, syscall_en=1 -> stall=1 for 3 cycles, rf_req 2 then 4, disp_valid pulse 1 cycle with disp_data=0xDEADBEEF, cnt_syscall=1, then stall=0.
- Halt: $v0=10 -> halt=1 and stall=1 held 100 cycles. rst_n=0 one edge -> halt=0, stall=0, cnt_syscall=0.
- Pause: $v0=50 -> stall high. resume at cycle 20 -> stall drops exactly one cycle later (DONE). Resume pulse while IDLE -> no effect.
- Unknown code: $v0=7 -> 3-cycle stall, no disp_valid, halt stays 0, cnt_syscall increments.
- Back-to-back: two display syscalls ($a0=1, then $a0=2) with syscall_en re-asserted immediately after DONE -> two disp_valid pulses with values 1 then 2, cnt_syscall=2.
- Reset mid-pause: assert rst_n=0 while PAUSE -> next cycle state IDLE, stall=0, disp_data=0, all outputs at reset values.
